// File: rtl/data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter
//
// Two-requester arbiter and sequencer in front of a single-ported synchronous
// data memory with a one-cycle registered read. Requester 0 is the CPU
// load/store path, requester 1 the debug/loader port. One transaction is in
// flight at a time; each ends with a one-cycle response pulse to its owner.
//
// Transaction flow (T = handshake cycle):
//   store : IDLE(T) -> ACCESS(T+1) -> RESP(T+2)
//   load  : IDLE(T) -> ACCESS(T+1) -> CAPTURE(T+2) -> RESP(T+3)
//   error : IDLE(T) -> RESP(T+1), memory strobes never raised
//
// Parameters
//   NUM_WORDS  : number of valid word addresses; addr >= NUM_WORDS is an error
//   FIXED_PRIO : 0 = round-robin, 1 = requester 0 always wins
//
// Ports
//   Clock          : system clock, all state changes on posedge
//   Reset_n        : asynchronous active-low reset
//   req_valid[1:0] : per-requester request valid
//   req_ready[1:0] : per-requester accept strobe (combinational, IDLE only)
//   req_write[1:0] : per-requester op, 1 = store, 0 = load
//   req_addr[63:0] : word addresses, requester r uses [32r+31:32r]
//   req_wdata[63:0]: store data, requester r uses [32r+31:32r]
//   rsp_valid[1:0] : one-cycle completion pulse on the owner's bit
//   rsp_err        : address out of range, valid with rsp_valid
//   rsp_rdata      : load data, valid with rsp_valid, held until next response
//   mem_address    : memory address (registered)
//   mem_write_data : memory write data (registered, 0 for loads)
//   mem_MemWrite   : memory write strobe (registered, one cycle)
//   mem_MemRead    : memory read strobe (registered, one cycle)
//   mem_read_data  : memory read data, valid the cycle after mem_MemRead
// ----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int unsigned NUM_WORDS  = 32,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] NumWords = 32'(NUM_WORDS);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAccess  = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StResp    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        last_grant_q;  // requester granted most recently
    logic        owner_q;       // requester owning the in-flight transaction
    logic        op_q;          // 1 = store
    logic        err_q;         // address out of range

    logic        winner;
    logic        handshake;
    logic        win_write;
    logic        win_err;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;

    // ------------------------------------------------------------------------
    // Arbitration: pick a candidate every cycle; it only matters in IDLE.
    // Round-robin favours the requester that was not granted last, falling
    // back to the last-granted one when the other is idle.
    // ------------------------------------------------------------------------
    always_comb begin
        winner = 1'b0;
        if (FIXED_PRIO != 0) begin
            winner = req_valid[0] ? 1'b0 : 1'b1;
        end else begin
            winner = req_valid[~last_grant_q] ? ~last_grant_q : last_grant_q;
        end
    end

    always_comb begin
        win_addr  = winner ? req_addr[63:32]  : req_addr[31:0];
        win_wdata = winner ? req_wdata[63:32] : req_wdata[31:0];
        win_write = req_write[winner];
        // Full 32-bit compare: high address bits are never ignored.
        win_err   = (win_addr >= NumWords);
        handshake = (state_q == StIdle) && req_valid[winner];
    end

    // At most one ready bit, and only while idle.
    always_comb begin
        req_ready = 2'b00;
        if (handshake) begin
            req_ready = winner ? 2'b10 : 2'b01;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (handshake) begin
                    state_d = win_err ? StResp : StAccess;
                end
            end
            StAccess:  state_d = op_q ? StResp : StCapture;
            StCapture: state_d = StResp;
            StResp:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            // Pretend requester 1 went last so requester 0 wins first.
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                last_grant_q <= winner;
                owner_q      <= winner;
                op_q         <= win_write;
                err_q        <= win_err;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory interface. Strobes are loaded on entry to ACCESS and cleared on
    // every other edge, so they are high for exactly the ACCESS cycle.
    // Address and write data hold between accesses.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_MemWrite   <= 1'b0;
            mem_MemRead    <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            mem_MemWrite <= 1'b0;
            mem_MemRead  <= 1'b0;
            if (handshake && !win_err) begin
                mem_MemWrite   <= win_write;
                mem_MemRead    <= ~win_write;
                mem_address    <= win_addr;
                mem_write_data <= win_write ? win_wdata : 32'h0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response data: captured from memory at the end of CAPTURE, zeroed on the
    // way into RESP for stores and errors, otherwise held.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_rdata <= '0;
        end else begin
            if (state_q == StCapture) begin
                rsp_rdata <= mem_read_data;
            end else if ((state_q == StAccess) && op_q) begin
                rsp_rdata <= '0;
            end else if (handshake && win_err) begin
                rsp_rdata <= '0;
            end
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        rsp_err   = 1'b0;
        if (state_q == StResp) begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
            rsp_err   = err_q;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter. Two instances run side by side: u_dut0 with
// round-robin arbitration and u_dut1 with fixed priority. Each has its own
// behavioural memory. A transaction-level model predicts, per cycle, which
// ready bit must be high, when the response pulse and memory strobes land
// (handshake cycle + fixed latency) and what data comes back (shadow memory).
module tb_data_mem_arbiter;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        Clock;
    logic        Reset_n;
    logic        mem_clear;

    logic [1:0]  req_valid_a  [2];
    logic [1:0]  req_ready_a  [2];
    logic [1:0]  req_write_a  [2];
    logic [63:0] req_addr_a   [2];
    logic [63:0] req_wdata_a  [2];
    logic [1:0]  rsp_valid_a  [2];
    logic        rsp_err_a    [2];
    logic [31:0] rsp_rdata_a  [2];
    logic [31:0] mem_addr_a   [2];
    logic [31:0] mem_wd_a     [2];
    logic        mem_we_a     [2];
    logic        mem_re_a     [2];
    logic [31:0] mem_rd_a     [2];

    logic [31:0] mem_arr [2][32];

    data_mem_arbiter #(.NUM_WORDS(32), .FIXED_PRIO(0)) u_dut0 (
        .Clock(Clock), .Reset_n(Reset_n),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
        .req_write(req_write_a[0]), .req_addr(req_addr_a[0]),
        .req_wdata(req_wdata_a[0]), .rsp_valid(rsp_valid_a[0]),
        .rsp_err(rsp_err_a[0]), .rsp_rdata(rsp_rdata_a[0]),
        .mem_address(mem_addr_a[0]), .mem_write_data(mem_wd_a[0]),
        .mem_MemWrite(mem_we_a[0]), .mem_MemRead(mem_re_a[0]),
        .mem_read_data(mem_rd_a[0])
    );

    data_mem_arbiter #(.NUM_WORDS(32), .FIXED_PRIO(1)) u_dut1 (
        .Clock(Clock), .Reset_n(Reset_n),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
        .req_write(req_write_a[1]), .req_addr(req_addr_a[1]),
        .req_wdata(req_wdata_a[1]), .rsp_valid(rsp_valid_a[1]),
        .rsp_err(rsp_err_a[1]), .rsp_rdata(rsp_rdata_a[1]),
        .mem_address(mem_addr_a[1]), .mem_write_data(mem_wd_a[1]),
        .mem_MemWrite(mem_we_a[1]), .mem_MemRead(mem_re_a[1]),
        .mem_read_data(mem_rd_a[1])
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous memory with registered read.
    always @(posedge Clock) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_clear) begin
                for (int k = 0; k < 32; k++) mem_arr[d][k] <= 32'h0;
            end else begin
                if (mem_we_a[d]) mem_arr[d][mem_addr_a[d][4:0]] <= mem_wd_a[d];
                if (mem_re_a[d]) mem_rd_a[d] <= mem_arr[d][mem_addr_a[d][4:0]];
            end
        end
    end

    // ---------------- bench state ----------------
    int n_total;
    int n_bad;
    int cyc;

    req_t qbuf [4][64];   // request queues, index d*2+r
    int   qh   [4];
    int   qt   [4];

    logic [31:0] shadow [2][32];
    int          idle_from  [2];
    int          rsp_cyc    [2];
    int          strobe_cyc [2];
    logic        last_g     [2];
    logic        rsp_owner_m[2];
    logic        rsp_err_m  [2];
    logic [31:0] rsp_data_m [2];
    logic [31:0] last_rdata [2];
    logic        upd_v      [2];
    logic [4:0]  upd_a      [2];
    logic [31:0] upd_d      [2];
    logic        st_rd      [2];
    logic        st_wr      [2];
    logic [31:0] st_addr    [2];
    logic [31:0] st_wd      [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int d, input int r, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
        int i;
        i = d * 2 + r;
        qbuf[i][qt[i]] = {wr, addr, wdata};
        qt[i]++;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            idle_from[d]  = 0;
            rsp_cyc[d]    = -1;
            strobe_cyc[d] = -1;
            last_g[d]     = 1'b1;
            last_rdata[d] = 32'h0;
            upd_v[d]      = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            qh[i] = 0;
            qt[i] = 0;
        end
    endtask

    task automatic drive_inputs();
        int i;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                i = d * 2 + r;
                if (qh[i] < qt[i]) begin
                    req_valid_a[d][r]        = 1'b1;
                    req_write_a[d][r]        = qbuf[i][qh[i]].wr;
                    req_addr_a[d][32*r +: 32]  = qbuf[i][qh[i]].addr;
                    req_wdata_a[d][32*r +: 32] = qbuf[i][qh[i]].wdata;
                end else begin
                    req_valid_a[d][r]        = 1'b0;
                    req_write_a[d][r]        = 1'b0;
                    req_addr_a[d][32*r +: 32]  = 32'h0;
                    req_wdata_a[d][32*r +: 32] = 32'h0;
                end
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d ready", tag, d), req_ready_a[d], 0);
            check($sformatf("%s d%0d rsp_valid", tag, d), rsp_valid_a[d], 0);
            check($sformatf("%s d%0d rsp_err", tag, d), rsp_err_a[d], 0);
            check($sformatf("%s d%0d rsp_rdata", tag, d), rsp_rdata_a[d], 0);
            check($sformatf("%s d%0d mem_addr", tag, d), mem_addr_a[d], 0);
            check($sformatf("%s d%0d mem_wd", tag, d), mem_wd_a[d], 0);
            check($sformatf("%s d%0d strobes", tag, d), {mem_re_a[d], mem_we_a[d]}, 0);
        end
    endtask

    // One cycle of the reference model for instance d, run at negedge+1.
    task automatic model_cycle(input int d);
        logic [1:0] v, er, ev, es;
        logic       other, w, err;
        int         i, lat;
        req_t       rq;
        v  = req_valid_a[d];
        er = 2'b00;
        if (cyc >= idle_from[d]) begin
            other = ~last_g[d];
            if (d == 1) w = v[0] ? 1'b0 : 1'b1;       // fixed-priority instance
            else        w = v[other] ? other : last_g[d];
            if (v[w]) er[w] = 1'b1;
        end
        check($sformatf("d%0d ready", d), req_ready_a[d], er);

        ev = (cyc == rsp_cyc[d]) ? (rsp_owner_m[d] ? 2'b10 : 2'b01) : 2'b00;
        check($sformatf("d%0d rsp_valid", d), rsp_valid_a[d], ev);
        check($sformatf("d%0d rsp_err", d), rsp_err_a[d], (ev != 2'b00) && rsp_err_m[d]);
        if (ev != 2'b00) begin
            check($sformatf("d%0d rsp_rdata", d), rsp_rdata_a[d], rsp_data_m[d]);
            last_rdata[d] = rsp_data_m[d];
            if (upd_v[d]) shadow[d][upd_a[d]] = upd_d[d];
            upd_v[d] = 1'b0;
        end else begin
            check($sformatf("d%0d rdata_hold", d), rsp_rdata_a[d], last_rdata[d]);
        end

        es = (cyc == strobe_cyc[d]) ? {st_rd[d], st_wr[d]} : 2'b00;
        check($sformatf("d%0d strobes", d), {mem_re_a[d], mem_we_a[d]}, es);
        if (cyc == strobe_cyc[d]) begin
            check($sformatf("d%0d mem_addr", d), mem_addr_a[d], st_addr[d]);
            check($sformatf("d%0d mem_wd", d), mem_wd_a[d], st_wd[d]);
        end

        if (er != 2'b00) begin
            w  = er[1];
            i  = d * 2 + int'(w);
            rq = qbuf[i][qh[i]];
            qh[i]++;
            if (qh[i] == qt[i]) begin
                qh[i] = 0;
                qt[i] = 0;
            end
            last_g[d]      = w;
            err            = (rq.addr >= 32'd32);
            lat            = err ? 1 : (rq.wr ? 2 : 3);
            rsp_cyc[d]     = cyc + lat;
            idle_from[d]   = cyc + lat + 1;
            rsp_owner_m[d] = w;
            rsp_err_m[d]   = err;
            rsp_data_m[d]  = (err || rq.wr) ? 32'h0 : shadow[d][rq.addr[4:0]];
            upd_v[d]       = rq.wr && !err;
            upd_a[d]       = rq.addr[4:0];
            upd_d[d]       = rq.wdata;
            if (err) begin
                strobe_cyc[d] = -1;
            end else begin
                strobe_cyc[d] = cyc + 1;
                st_rd[d]      = !rq.wr;
                st_wr[d]      = rq.wr;
                st_addr[d]    = rq.addr;
                st_wd[d]      = rq.wr ? rq.wdata : 32'h0;
            end
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic step();
        drive_inputs();
        #1;
        for (int d = 0; d < 2; d++) model_cycle(d);
        @(negedge Clock);
        cyc++;
    endtask

    function automatic int pending();
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) if (qh[i] < qt[i]) p++;
        for (int d = 0; d < 2; d++) if (cyc < idle_from[d]) p++;
        return p;
    endfunction

    task automatic drain(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (pending() == 0) break;
            step();
        end
        check($sformatf("%s drained", tag), pending(), 0);
    endtask

    task automatic do_reset();
        model_reset();
        drive_inputs();
        Reset_n = 1'b0;
        #1;
        check_zero_outputs("reset");
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) begin
            a = $urandom;
            if (a < 32'd32) a = a + 32'd32;
        end else begin
            a = 32'($urandom_range(0, 31));
        end
        return a;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        n_total   = 0;
        n_bad     = 0;
        cyc       = 0;
        mem_clear = 1'b1;
        Reset_n   = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 32; k++) shadow[d][k] = 32'h0;
        model_reset();
        drive_inputs();
        #1;
        check_zero_outputs("por");
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        mem_clear = 1'b0;
        Reset_n   = 1'b1;

        // Store then load on requester 0.
        push(0, 0, 1'b1, 32'd5, 32'hDEADBEEF);
        push(0, 0, 1'b0, 32'd5, 32'h0);
        drain("st_ld", 50);

        // Contention straight out of reset.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(0, 0, 1'b0, 32'($urandom_range(0, 31)), 32'h0);
            push(0, 1, 1'b0, 32'($urandom_range(0, 31)), 32'h0);
        end
        for (int k = 0; k < 6; k++) push(1, 0, 1'b0, 32'($urandom_range(0, 31)), 32'h0);
        for (int k = 0; k < 3; k++) push(1, 1, 1'b0, 32'($urandom_range(0, 31)), 32'h0);
        drain("contend", 100);

        // Out-of-range addresses.
        push(0, 0, 1'b0, 32'd32, 32'h0);
        push(0, 0, 1'b1, 32'h8000_0005, 32'h1234_5678);
        push(1, 1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        drain("errors", 50);

        // Fill through requester 1, read back through requester 0.
        for (int k = 0; k < 32; k++) begin
            push(0, 1, 1'b1, 32'(k), 32'(k + 1));
            push(1, 1, 1'b1, 32'(k), 32'(k + 1) ^ 32'hA500_0000);
        end
        drain("fill", 200);
        for (int k = 0; k < 32; k++) begin
            push(0, 0, 1'b0, 32'(k), 32'h0);
            push(1, 0, 1'b0, 32'(k), 32'h0);
        end
        drain("readback", 200);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (qh[i] == qt[i] && $urandom_range(0, 3) == 0)
                    push(i / 2, i % 2, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
            step();
        end
        drain("random", 100);

        // Reset while a store sits in ACCESS.
        push(0, 0, 1'b1, 32'd9, 32'hA5A5_0009);
        for (int k = 0; k < 10; k++) begin
            if (strobe_cyc[0] == cyc) break;
            step();
        end
        drive_inputs();
        #1;
        check("abort memwrite_hi", mem_we_a[0], 1);
        Reset_n = 1'b0;
        #1;
        check("abort memwrite_drop", mem_we_a[0], 0);
        check("abort memread", mem_re_a[0], 0);
        @(negedge Clock);
        check("abort rsp_valid", rsp_valid_a[0], 0);
        @(negedge Clock);
        check("abort rsp_valid2", rsp_valid_a[0], 0);
        Reset_n = 1'b1;
        model_reset();
        push(0, 0, 1'b0, 32'd9, 32'h0);
        drain("post_abort", 50);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 32-word synchronous data memory.
- Requester 0 is the CPU load/store path; requester 1 is the debug/loader port used for memory initialisation and readback.
- Serialises requests through a valid/ready handshake and drives the memory's MemRead/MemWrite/address/write_data.
- Handles the memory's one-cycle registered read latency and returns a one-cycle response pulse to the requester that owned the transaction.

Parameters:
- NUM_WORDS, 32: number of valid word addresses; any address >= NUM_WORDS is an error.
- FIXED_PRIO, 0: 0 = round-robin between requesters; 1 = requester 0 always wins.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit r belongs to requester r.
- req_ready  out  2  per-requester accept strobe.
- req_write  in  2  per-requester op: 1 = store, 0 = load.
- req_addr  in  64  word addresses; requester r uses bits [32r+31:32r].
- req_wdata  in  64  store data; requester r uses bits [32r+31:32r].
- rsp_valid  out  2  one-cycle completion pulse to the owning requester.
- rsp_err  out  1  valid with rsp_valid; 1 = address out of range.
- rsp_rdata  out  32  load data, valid with rsp_valid.
- mem_address  out  32  to memory address.
- mem_write_data  out  32  to memory write_data.
- mem_MemWrite  out  1  to memory MemWrite.
- mem_MemRead  out  1  to memory MemRead.
- mem_read_data  in  32  from memory read_data; valid the cycle after a MemRead cycle.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; all outputs 0; last_grant=1, so requester 0 wins the first round-robin decision.
  - Any in-flight transaction is dropped with no response. mem_MemWrite/mem_MemRead fall immediately.
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - req_ready is combinational, nonzero only in IDLE, and one-hot at most.
  - Winner selection:
    - FIXED_PRIO=1: requester 0 wins if valid, else requester 1.
    - FIXED_PRIO=0: the requester other than last_grant wins if valid, else last_grant.
  - req_ready[w]=req_valid[w]. On the handshake (valid&ready), latch w, op, addr and wdata; update last_grant=w.
  - If addr >= NUM_WORDS (full 32-bit compare): next state RESP with err=1.
  - Otherwise: next state ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_* outputs are registered and loaded on entry to ACCESS.
  - mem_MemWrite=op, mem_MemRead=~op, mem_address=addr, mem_write_data=wdata (0 for loads).
  - Store: next state RESP. Load: next state CAPTURE.
  - On exit, mem_MemWrite/mem_MemRead clear to 0. mem_address and mem_write_data hold their last value.
- CAPTURE (loads only, 1 cycle):
  - Memory strobes are low.
  - rsp_rdata is loaded from mem_read_data at the posedge ending this cycle.
  - Next state RESP.
- RESP (1 cycle):
  - rsp_valid[w]=1; the other bit stays 0.
  - rsp_err=err.
  - rsp_rdata = captured data for loads; 0 for stores and errors.
  - Next state IDLE. There is no response backpressure.
  - rsp_valid and rsp_err are 0 outside RESP. rsp_rdata holds its value until the next response.
- Latency from the handshake cycle T:
  - store: rsp_valid in T+2.
  - load: rsp_valid in T+3.
  - error: rsp_valid in T+1.
- Memory strobes are never asserted for error transactions.
- MemRead and MemWrite are never high together.
- Requests arriving outside IDLE wait; req_valid must stay high until ready.
- Both requesters valid in IDLE: exactly one is granted per the arbitration rule.
- Under continuous contention in round-robin mode, grants strictly alternate.
- Address is a word index; no byte addressing or alignment checks.

Test Plan:
- Requester 0 stores 0xDEADBEEF to address 5, then loads address 5 -> single-cycle mem_MemWrite with mem_address=5; rsp_valid[0] in T+2 with err=0; load returns rsp_rdata=0xDEADBEEF in T+3.
- Both requesters valid with loads, FIXED_PRIO=0, immediately after reset -> grant order 0,1,0,1; each rsp_valid pulse lands only on the owner's bit.
- FIXED_PRIO=1, requester 0 holds req_valid continuously -> requester 1 never granted; releasing requester 0 grants requester 1 in the next IDLE cycle.
- Load with address 32, then store with address 0x8000_0005 -> rsp_err=1 at T+1; mem_MemRead/mem_MemWrite stay 0 throughout; rsp_rdata=0.
- Reset_n pulled low during ACCESS of a store -> mem_MemWrite drops asynchronously; no rsp_valid; after release, the next requester 0 request is granted from IDLE.
- Requester 1 writes 0x1..0x20 to addresses 0..31, then requester 0 reads all 32 -> data matches; one transaction every 3 (store) or 4 (load) cycles under back-to-back requests.
